// File: rtl/prog_chain_loader.sv
// prog_chain_loader
// Loads a byte-wide bitstream serially into the CB/CLB/SB programming chain,
// then recirculates the chain once (prog_out -> prog_in) and compares a CRC-8
// of the recirculated stream against the CRC of what was sent.
//
// Handshake: a byte transfers on every rising prog_clk edge where
// data_valid && data_ready. data_ready is decoded from state alone (FETCH)
// and never depends on data_valid; data_valid may be held or dropped freely.
module prog_chain_loader #(
    parameter int CHAIN_LEN = 128
) (
    input  logic       prog_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       chain_out,
    output logic       prog_in,
    output logic       prog_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Bytes consumed per load; fixed by the chain length.
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    // bits_left must hold CHAIN_LEN; sized from the byte count so it also
    // covers the rounded-up value.
    localparam int BL_W   = $clog2(NBYTES * 8 + 1);
    localparam int CNT_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [7:0]      r_sreg;
    logic [3:0]      r_nb;
    logic [BL_W-1:0] r_bits_left;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]      r_crc_tx;
    logic [7:0]      r_crc_rx;
    logic            r_err;

    logic [3:0]      w_nb_load;
    logic [BL_W-1:0] w_bits_left_dec;
    logic            w_shift_last;
    logic            w_verify_last;
    logic [7:0]      w_crc_tx_next;
    logic [7:0]      w_crc_rx_next;

    // One bit of CRC-8, polynomial 0x07, MSB-first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Bits to shift from the next byte: a full byte, or the remainder on the
    // final partial byte (its low bits are simply never shifted out).
    assign w_nb_load       = (r_bits_left >= BL_W'(8)) ? 4'd8 : r_bits_left[3:0];
    assign w_bits_left_dec = r_bits_left - BL_W'(1);
    assign w_shift_last    = (r_nb == 4'd1);
    assign w_verify_last   = (r_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_crc_tx_next   = crc8_step(r_crc_tx, r_sreg[7]);
    assign w_crc_rx_next   = crc8_step(r_crc_rx, chain_out);

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (data_valid) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_state_next = (w_bits_left_dec != '0) ? S_FETCH : S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (w_verify_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE immediately, which zeroes every
    // state-decoded output without waiting for a clock.
    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: shift register, counters, both CRCs and the sticky error.
    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            r_sreg      <= 8'h00;
            r_nb        <= 4'd0;
            r_bits_left <= '0;
            r_cnt       <= '0;
            r_crc_tx    <= 8'h00;
            r_crc_rx    <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err       <= 1'b0;
                        r_crc_tx    <= 8'h00;
                        r_crc_rx    <= 8'h00;
                        r_bits_left <= BL_W'(CHAIN_LEN);
                    end
                end
                S_FETCH: begin
                    if (data_valid) begin
                        r_sreg <= data_in;
                        r_nb   <= w_nb_load;
                    end
                end
                S_SHIFT: begin
                    r_sreg      <= {r_sreg[6:0], 1'b0};
                    r_crc_tx    <= w_crc_tx_next;
                    r_nb        <= r_nb - 4'd1;
                    r_bits_left <= w_bits_left_dec;
                    if (w_shift_last && (w_bits_left_dec == '0)) begin
                        r_cnt <= '0;
                    end
                end
                S_VERIFY: begin
                    // chain_out is only meaningful here; during the load it
                    // still carries the previous configuration.
                    r_crc_rx <= w_crc_rx_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_verify_last) begin
                        r_err <= (w_crc_rx_next != r_crc_tx);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; prog_in recirculates the chain in VERIFY.
    assign data_ready = (r_state == S_FETCH);
    assign prog_en    = (r_state == S_SHIFT) || (r_state == S_VERIFY);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign prog_in    = (r_state == S_SHIFT)  ? r_sreg[7] :
                        (r_state == S_VERIFY) ? chain_out : 1'b0;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: a 20-bit and a 16-bit instance, each driving
// a behavioural chain model. A table of load scenarios is replayed; sent bits
// are queued when a byte is accepted and checked when prog_en shifts them out.
module tb_prog_chain_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       stuck = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;

    logic a_start, a_valid, a_ready, a_cout, a_pin, a_pen, a_busy, a_done, a_err;
    logic b_start, b_valid, b_ready, b_cout, b_pin, b_pen, b_busy, b_done, b_err;
    logic [2:0] a_dbg, b_dbg;

    logic w_ready, w_pen, w_pin, w_busy, w_done, w_err;

    logic [19:0] ch_a = '0;
    logic [15:0] ch_b = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:0] exp_q[$];
    logic [0:0] sent_bits[$];

    typedef struct {
        int         sel;
        int         len;
        int         nbytes;
        logic [7:0] b0, b1, b2;
        int         stall_idx;
        int         stall_cyc;
        int         stuck;
        int         sp1, sp2;
        int         rst_at;
        int         exp_done;
        int         exp_hs;
        int         exp_err;
    } vec_t;

    vec_t tbl[9];

    // Clock.
    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign a_valid = data_valid & ~sel;
    assign b_start = start & sel;
    assign b_valid = data_valid & sel;

    assign w_ready = sel ? b_ready : a_ready;
    assign w_pen   = sel ? b_pen   : a_pen;
    assign w_pin   = sel ? b_pin   : a_pin;
    assign w_busy  = sel ? b_busy  : a_busy;
    assign w_done  = sel ? b_done  : a_done;
    assign w_err   = sel ? b_err   : a_err;

    assign a_cout = ch_a[19];
    assign b_cout = ch_b[15];

    // Chain models: shift on prog_en; optional stuck-at-0 cell at bit 7.
    always @(posedge clk) begin
        if (a_pen) begin
            ch_a <= stuck ? ({ch_a[18:0], a_pin} & ~20'h00080) : {ch_a[18:0], a_pin};
        end
        if (b_pen) begin
            ch_b <= {ch_b[14:0], b_pin};
        end
    end

    prog_chain_loader #(.CHAIN_LEN(20)) u_dut20 (
        .prog_clk(clk), .rst(rst), .start(a_start), .data_in(data_in),
        .data_valid(a_valid), .data_ready(a_ready), .chain_out(a_cout),
        .prog_in(a_pin), .prog_en(a_pen), .busy(a_busy), .done(a_done),
        .err(a_err), .dbg_state(a_dbg)
    );

    prog_chain_loader #(.CHAIN_LEN(16)) u_dut16 (
        .prog_clk(clk), .rst(rst), .start(b_start), .data_in(data_in),
        .data_valid(b_valid), .data_ready(b_ready), .chain_out(b_cout),
        .prog_in(b_pin), .prog_en(b_pen), .busy(b_busy), .done(b_done),
        .err(b_err), .dbg_state(b_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Replays one load scenario, with edge 0 being the edge that samples start.
    task automatic run_vec(input vec_t v);
        logic [7:0]  bytes[3];
        logic [19:0] ec;
        logic [19:0] act_chain;
        int k, bi, hs, pen_cnt, stall_left, done_edge, nbits;
        logic got_err, aborted;

        bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
        sel   = (v.sel != 0);
        stuck = (v.stuck != 0);
        exp_q.delete();
        sent_bits.delete();
        k = 0; bi = 0; hs = 0; pen_cnt = 0; stall_left = v.stall_cyc;
        done_edge = -1; got_err = 1'b0; aborted = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(w_busy), 1);
        check("err_cleared_on_start", int'(w_err), 0);

        while (k < 200) begin
            if (k == v.rst_at) begin
                check("busy_before_reset", int'(w_busy), 1);
                rst = 1'b1;
                data_valid = 1'b0;
                #1;
                check("outputs_in_reset",
                      int'({w_ready, w_pen, w_pin, w_busy, w_done, w_err}), 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (w_pen) begin
                if (pen_cnt < v.len) begin
                    if (exp_q.size() == 0) begin
                        check("load_queue_has_bit", 0, 1);
                    end else begin
                        check("load_bit", int'(w_pin), int'(exp_q.pop_front()));
                    end
                end else if (!stuck && (pen_cnt - v.len) < sent_bits.size()) begin
                    check("verify_bit", int'(w_pin), int'(sent_bits[pen_cnt - v.len]));
                end
                pen_cnt++;
            end
            if (w_ready) begin
                check("pen_low_in_fetch", int'(w_pen), 0);
            end
            if (w_done) begin
                done_edge = k;
                got_err = w_err;
                break;
            end
            start = (k == v.sp1) || (k == v.sp2);
            if (bi < v.nbytes && !(bi == v.stall_idx && stall_left > 0)) begin
                data_valid = 1'b1;
                data_in = bytes[bi];
            end else begin
                data_valid = 1'b0;
                data_in = 8'($urandom_range(0, 255));
            end
            if (w_ready && data_valid) begin
                nbits = (v.len - 8 * bi >= 8) ? 8 : v.len - 8 * bi;
                for (int j = 7; j >= 8 - nbits; j--) begin
                    exp_q.push_back(data_in[j]);
                    sent_bits.push_back(data_in[j]);
                end
                bi++;
                hs++;
            end else if (w_ready && bi == v.stall_idx && stall_left > 0) begin
                stall_left--;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        data_valid = 1'b0;
        if (aborted) begin
            return;
        end
        if (done_edge < 0) begin
            check("done_within_budget", 0, 1);
            return;
        end
        check("done_edge", done_edge, v.exp_done);
        check("handshakes", hs, v.exp_hs);
        check("err_at_done", int'(got_err), v.exp_err);
        check("prog_en_cycles", pen_cnt, 2 * v.len);
        if (!stuck) begin
            ec = '0;
            for (int i = 0; i < v.len; i++) begin
                ec[v.len - 1 - i] = sent_bits[i];
            end
            act_chain = sel ? {4'b0000, ch_b} : ch_a;
            check("chain_contents", int'(act_chain), int'(ec));
        end
        @(posedge clk);
        @(negedge clk);
        check("busy_after_done", int'(w_busy), 0);
        check("done_one_cycle", int'(w_done), 0);
        repeat (3) @(negedge clk);
        check("err_sticky_idle", int'(w_err), v.exp_err);
    endtask

    initial begin
        //        sel len nb  b0     b1     b2    stIdx stC stuck sp1 sp2 rst  done hs err
        tbl[0] = '{0, 20, 3, 8'hA5, 8'h3C, 8'hF0, -1, 0, 0, -1, -1, -1, 43, 3, 0};
        tbl[1] = '{1, 16, 2, 8'hFF, 8'h00, 8'h00, -1, 0, 0, -1, -1, -1, 34, 2, 0};
        tbl[2] = '{0, 20, 3, 8'hA5, 8'h3C, 8'hF0,  1, 5, 0, -1, -1, -1, 48, 3, 0};
        tbl[3] = '{0, 20, 3, 8'hFF, 8'hFF, 8'hF0, -1, 0, 1, -1, -1, -1, 43, 3, 1};
        tbl[4] = '{0, 20, 3, 8'hA5, 8'h3C, 8'hF0, -1, 0, 0,  5, 30, -1, 43, 3, 0};
        tbl[5] = '{0, 20, 3, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), -1, 0, 0, -1, -1, -1, 43, 3, 0};
        tbl[6] = '{1, 16, 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'h00, 1, 2, 0, -1, -1, -1, 36, 2, 0};
        tbl[7] = '{0, 20, 3, 8'h5A, 8'hC3, 8'h0F, -1, 0, 0, -1, -1, 13, 0, 0, 0};
        tbl[8] = '{0, 20, 3, 8'h5A, 8'hC3, 8'h0F, -1, 0, 0, -1, -1, -1, 43, 3, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_a_outputs", int'({a_ready, a_pen, a_pin, a_busy, a_done, a_err}), 0);
        check("reset_b_outputs", int'({b_ready, b_pen, b_pin, b_busy, b_done, b_err}), 0);
        check("reset_a_state", int'(a_dbg), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_a_outputs", int'({a_ready, a_pen, a_pin, a_busy, a_done, a_err}), 0);

        for (int t = 0; t < 9; t++) begin
            run_vec(tbl[t]);
            repeat (2) @(negedge clk);
        end

        // Data offered while idle must not be taken.
        sel = 1'b0;
        data_valid = 1'b1;
        data_in = 8'h99;
        @(negedge clk);
        check("no_ready_in_idle", int'(w_ready), 0);
        data_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_chain_loader.md
# prog_chain_loader

Configuration loader that sits directly upstream of the CB/CLB/SB programming chain. It accepts the bitstream as bytes over a valid/ready handshake and serializes it onto `prog_in` with `prog_en` gating the chain's shift. It then recirculates the chain once, through `prog_out` back to `prog_in`, to verify the loaded contents by CRC without altering them. It reports `busy`, a one-cycle `done`, and a sticky `err`.

## Interface
- `CHAIN_LEN`, default 128: total configuration bits in the chain, counted from loader `prog_in` to chain-tail `prog_out`; ≥ 2.
- `NBYTES`, derived as ceil(CHAIN_LEN/8): the number of bytes consumed per load. It is not overridable.

- `prog_clk`: in, 1. Single clock for the loader and the chain.
- `rst`: in, 1. Reset is asynchronous and active-high.
- `start`: in, 1. Single-cycle request to begin a load. Sampled only in IDLE.
- `data_in`: in, 8. Bitstream byte.
- `data_valid`: in, 1. `data_in` is valid.
- `data_ready`: out, 1. Loader accepts `data_in` this cycle.
- `chain_out`: in, 1. Connected to the tail `prog_out` of the chain.
- `prog_in`: out, 1. Serial configuration data to the chain head.
- `prog_en`: out, 1. Chain shift enable.
- `busy`: out, 1. High whenever state ≠ IDLE.
- `done`: out, 1. One-cycle pulse at the end of verification.
- `err`: out, 1. CRC mismatch on the last load. Sticky.

## Operation
- The FSM states are IDLE, FETCH, SHIFT, VERIFY and DONE.
- **IDLE**
  - All outputs are low except `err`, which holds its value.
  - `start=1` causes the following at the next edge:
    - clear `err`, `crc_tx` and `crc_rx`;
    - set `bits_left` = CHAIN_LEN;
    - go to FETCH.
- **FETCH**
  - `data_ready=1` and `prog_en=0`.
  - On `data_valid&data_ready`, load `data_in` into `sreg[7:0]` and set `nb` = min(8, `bits_left`).
  - Then go to SHIFT.
- **SHIFT**
  - Outputs: `prog_en=1`, `prog_in=sreg[7]`, so each byte is sent MSB first.
  - Each edge performs the following:
    - shift `sreg` left;
    - fold `prog_in` into `crc_tx`;
    - decrement `nb` and `bits_left`.
  - When `nb` reaches 0:
    - go to FETCH if `bits_left>0`;
    - otherwise clear `cnt` and go to VERIFY.
  - In the final byte, only the top `CHAIN_LEN mod 8` bits are shifted. The remaining low bits are discarded.
  - The first bit sent ends at the chain tail.
- **VERIFY**
  - Runs for CHAIN_LEN cycles.
  - Outputs: `prog_en=1`, and `prog_in=chain_out`, which is a combinational path so the chain recirculates.
  - Each edge folds `chain_out` into `crc_rx`.
  - After exactly CHAIN_LEN shifts the chain contents equal the loaded contents, and `chain_out` has emitted the bits in their original send order.
  - The last VERIFY edge sets `err` = (`crc_rx_next` ≠ `crc_tx`) and goes to DONE.
- **DONE**
  - `done=1` for one cycle, then IDLE.
- **CRC**
  - CRC-8, polynomial 0x07, init 0x00, processed bitwise.
  - Update rule: `fb=crc[7]^bit`; `crc={crc[6:0],0}^(fb?8'h07:0)`.
- **Boundary conditions**
  - `start` in any state other than IDLE is ignored.
  - When `data_valid=0` in FETCH, the loader stalls with `prog_en=0`, so the chain holds its contents.
  - `data_in` is never accepted outside FETCH.
  - `chain_out` is ignored during FETCH and SHIFT, because it carries the old contents.
  - `rst` asserted mid-operation immediately forces IDLE and drives every output to 0, including `err`. Chain contents are then undefined and the host must reload.

## Timing
- Reset values: `data_ready`, `prog_en`, `prog_in`, `busy`, `done` and `err` are all 0.
- Registered elements: the state, `sreg`, the counters and both CRCs.
- Outputs decoded from state, with no extra latency: `prog_en`, `data_ready`, `busy` and `done`.
  - `prog_in` is muxed: `sreg[7]` in SHIFT, `chain_out` in VERIFY, and 0 otherwise.
- Cycle counts, taking the edge that samples `start` as edge 0 and with `data_valid` held high:
  - byte k is accepted one edge after the previous byte's last shift;
  - LOAD spans edges 1 to NBYTES+CHAIN_LEN;
  - VERIFY spans the next CHAIN_LEN edges;
  - `done` is high in the cycle following edge NBYTES+2·CHAIN_LEN;
  - `busy` falls one edge later.
- Each cycle that `data_valid` is low in FETCH delays `done` by one cycle.

## Test plan
- **Nominal load, CHAIN_LEN=20.**
  - Stimulus: bytes 0xA5, 0x3C, 0xF0 with `data_valid` held high, driving a behavioural 20-bit chain model.
  - Expected: the chain shifts in 1010010100111100 followed by 1111, giving 20 `prog_en` cycles before VERIFY.
  - Expected: `done` after edge 43, `err=0`, and chain contents unchanged after VERIFY.
- **Exact multiple, CHAIN_LEN=16.**
  - Stimulus: bytes 0xFF, 0x00.
  - Expected: exactly 2 `data_ready` handshakes, `done` after edge 34, `err=0`.
- **Stall.**
  - Stimulus: deassert `data_valid` for 5 cycles before the second byte.
  - Expected: `prog_en=0` throughout the stall, `done` delayed to after edge 48, `err=0`.
- **Fault detection.**
  - Stimulus: the chain model has bit 7 stuck at 0, and the load is 0xFF, 0xFF, 0xF0.
  - Expected: `err=1` at `done`.
  - Expected: `err` stays high through IDLE and clears on the next `start`.
- **start while busy.**
  - Stimulus: pulse `start` during SHIFT and during VERIFY.
  - Expected: no restart, byte count and `done` timing identical to the nominal case.
- **Reset mid-load.**
  - Stimulus: assert `rst` during SHIFT of byte 2.
  - Expected: all outputs are 0 asynchronously.
  - Expected: a subsequent full load completes with `err=0`.
